// File: rtl/seq_subtractor_32.sv
// Multi-cycle two's-complement subtractor: diff = X - Y, one SLICE-bit slice per clock
// with the carry registered between slices and a start/busy/done handshake.
module seq_subtractor_32 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned SW     = SLICE + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] xr;
  logic [WIDTH-1:0] yr;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic [KW-1:0]    k;
  logic [SLICE-1:0] xs;
  logic [SLICE-1:0] ys;
  logic [SW-1:0]    sum;
  logic             last_slice;
  logic             start_acc;

  assign last_slice = (k == KW'(NSLICE - 1));
  assign start_acc  = start && (state != RUN);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_slice) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decode straight from the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Select the active slice, add it with the registered carry, merge into the result
  always_comb begin
    xs      = '0;
    ys      = '0;
    res_nxt = res;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (k == KW'(i)) begin
        xs = xr[i*SLICE +: SLICE];
        ys = yr[i*SLICE +: SLICE];
      end
    end
    sum = {1'b0, xs} + {1'b0, ys} + SW'(carry);
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (k == KW'(i)) begin
        res_nxt[i*SLICE +: SLICE] = sum[SLICE-1:0];
      end
    end
  end

  // Operand latch, slice iteration and result/flag update on DONE entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr       <= '0;
      yr       <= '0;
      res      <= '0;
      carry    <= 1'b0;
      k        <= '0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (start_acc) begin
      xr    <= X;
      yr    <= ~Y;
      carry <= 1'b1;
      k     <= '0;
    end else if (state == RUN) begin
      res   <= res_nxt;
      carry <= sum[SLICE];
      k     <= last_slice ? '0 : k + KW'(1);
      if (last_slice) begin
        diff     <= res_nxt;
        borrow   <= ~sum[SLICE];
        // yr holds ~Y, so Y's sign bit is the inverse of yr's
        overflow <= (xr[WIDTH-1] != ~yr[WIDTH-1]) && (res_nxt[WIDTH-1] != xr[WIDTH-1]);
        zero     <= (res_nxt == '0);
      end
    end
  end

endmodule

// File: doc/seq_subtractor_32.md
Name: seq_subtractor_32

Overview:
- Multi-cycle two's-complement subtractor that computes DIFF = X − Y, the inverse operation of the ripple-carry adder chain in the adder/subtractor unit.
- Processes one SLICE-bit slice per clock, with carry registered between slices. This gives an 8-bit-wide datapath with a short critical path.
- Sits beside the combinational adders in ADDER_SUBTR_UNIT. Driven by the ALU control FSM through a start/done handshake.

Parameters:
- WIDTH, 32, operand and result width; must be an integer multiple of SLICE.
- SLICE, 8, bits processed per cycle. NSLICE = WIDTH/SLICE (4 by default).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high; clears all state immediately.
- start  input  1  request; sampled only when busy=0.
- X  input  WIDTH  minuend, signed or unsigned; sampled with an accepted start.
- Y  input  WIDTH  subtrahend; sampled with an accepted start.
- diff  output  WIDTH  result X − Y mod 2^WIDTH.
- borrow  output  1  unsigned borrow: 1 when X < Y unsigned. Equals the inverted final carry.
- overflow  output  1  signed overflow of X − Y.
- zero  output  1  1 when diff == 0.
- busy  output  1  high while slices are being computed.
- done  output  1  one-cycle pulse when results become valid.

Behaviour:
- Reset state, entered asynchronously on rst=1:
  - FSM in IDLE; slice index 0; internal carry 0.
  - Operand registers 0.
  - Outputs: diff=0, borrow=0, overflow=0, zero=0, busy=0, done=0.
- FSM states: IDLE, RUN, DONE.
- Start acceptance: start=1 is accepted on a rising edge while in IDLE or DONE.
  - Latch X into xr and the bitwise inverse ~Y into yr.
  - Set carry=1 (two's-complement +1) and slice index k=0.
  - Go to RUN.
- RUN, each edge for k = 0..NSLICE−1:
  - {c, s} = xr[k-th slice] + yr[k-th slice] + carry, computed as an (SLICE+1)-bit sum.
  - Write s into the k-th slice of the internal result register; carry ← c; k ← k+1.
  - After the edge that processes k=NSLICE−1, go to DONE.
- DONE entry, updated on that same edge:
  - diff ← result register; borrow ← ~c_final.
  - overflow ← (X[WIDTH−1] ≠ Y[WIDTH−1]) && (diff[WIDTH−1] ≠ X[WIDTH−1]), using the latched operands.
  - zero ← (diff == 0).
- Output timing:
  - busy=1 exactly in RUN (NSLICE cycles).
  - done=1 exactly in DONE (1 cycle).
  - diff and flags change only on DONE entry and hold until the next DONE entry or reset.
- Latency: start sampled at edge E0 gives busy high cycles 1..NSLICE and done high in cycle NSLICE+1.
  - Default: done 5 cycles after the start cycle.
- DONE exit:
  - If start=1, go directly to RUN with new operands (back-to-back operation; no IDLE bubble).
  - Otherwise go to IDLE.
- start while in RUN: ignored. No queuing, no effect on the current computation or the operand registers.
- X/Y changing during RUN: no effect, because operands are latched.
- Reset mid-operation: abort immediately; all outputs return to reset values, including discarding the previously held diff. No done pulse is produced for the aborted operation.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - Carry propagates only through the registered carry between slices.
  - No combinational path from X/Y/start to any output.

Test Plan:
- X=100, Y=58, start pulse → busy for 4 cycles; done in cycle 5; diff=42, borrow=0, overflow=0, zero=0.
- X=5, Y=7 → diff=0xFFFFFFFE, borrow=1, overflow=0, zero=0.
- X=0x00000100, Y=1 → diff=0x000000FF, borrow=0. Checks carry propagating across the slice-0/slice-1 boundary. Then X=0x80000000, Y=1 → diff=0x7FFFFFFF, overflow=1, borrow=0.
- X=Y=0xDEADBEEF → diff=0, zero=1, borrow=0. Next, X=0x7FFFFFFF, Y=0xFFFFFFFF (−1) → diff=0x80000000, overflow=1, borrow=1.
- Start X=10, Y=3; re-pulse start with X=1, Y=1 in cycle 2 → ignored; diff=7 at done. Then hold start=1 in the DONE cycle with X=9, Y=4 → busy rises next cycle; second done 5 cycles later with diff=5; diff stays 7 in between.
- Start X=50, Y=20; assert rst asynchronously mid-cycle in cycle 3 → busy=0, diff=0 immediately; no done pulse. After release, a new start with X=50, Y=20 completes normally with diff=30.
